// File: rtl/instr_prefetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian words from byte memory
// and queues them with their PC in a small FIFO for the core.
module instr_prefetch_unit #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [7:0]               imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_out,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_asm;
  logic [31:0]         r_hold;
  logic [31:0]         r_mem_word [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc [DEPTH];
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;

  logic                w_pop;
  logic                w_can_push;
  logic                w_push;
  logic                w_stall;
  logic                w_fire;
  logic [31:0]         w_word;
  logic [31:0]         w_push_word;

  assign imem_addr  = r_fetch_pc + ADDR_W'(r_byte_cnt);
  assign inst_valid = (r_count != '0);
  assign inst_out   = r_mem_word[r_rd_ptr];
  assign inst_pc    = r_mem_pc[r_rd_ptr];
  assign fifo_count = r_count;

  assign w_pop      = inst_valid & inst_ready;
  assign w_can_push = (r_count != CW'(DEPTH)) | w_pop;
  assign w_word     = {r_asm, imem_rdata};
  assign w_fire     = fetch_en & (r_byte_cnt == 2'd3);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_stall     = 1'b0;
    w_push_word = w_word;
    unique case (r_state)
      FETCH: begin
        if (w_fire) begin
          if (w_can_push) begin
            w_push = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_push_word = r_hold;
        if (w_can_push) begin
          w_push      = 1'b1;
          w_state_nxt = FETCH;
        end
      end
    endcase
    // a redirect wins over everything, including a completing word
    if (redirect_valid) begin
      w_state_nxt = FETCH;
      w_push      = 1'b0;
      w_stall     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_hold     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_word[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem_word[r_wr_ptr] <= w_push_word;
        r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
        r_fetch_pc           <= r_fetch_pc + ADDR_W'(4);
        r_byte_cnt           <= '0;
      end else if (r_state == FETCH && fetch_en &&
                   r_byte_cnt != 2'd3) begin
        case (r_byte_cnt)
          2'd0:    r_asm[23:16] <= imem_rdata;
          2'd1:    r_asm[15:8]  <= imem_rdata;
          default: r_asm[7:0]   <= imem_rdata;
        endcase
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_stall) r_hold <= w_word;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench: expected fetch stream is sequential words from the
// current start PC; monitors compare every accepted instruction.
module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b1;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic [4:0]  imem_addr;
  logic [7:0]  imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [4:0]  inst_pc;
  logic [2:0]  fifo_count;

  logic        fetch_en2 = 1'b1;
  logic        ready2 = 1'b1;
  logic        redir2 = 1'b0;
  logic [4:0]  rpc2 = '0;
  logic [4:0]  imem_addr2;
  logic [7:0]  imem_rdata2;
  logic        inst_valid2;
  logic [31:0] inst_out2;
  logic [4:0]  inst_pc2;
  logic [2:0]  fifo_count2;

  logic [7:0]  mem [32];
  logic [4:0]  q1[$];
  logic [4:0]  q2[$];
  logic [4:0]  nxt1;
  logic [4:0]  nxt2;
  int          compared = 0;
  int          mismatched = 0;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata2 = mem[imem_addr2];

  always #5 clk = ~clk;

  instr_prefetch_unit #(.ADDR_W(5), .DEPTH(4), .RESET_PC(5'h00)) u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_count(fifo_count)
  );

  instr_prefetch_unit #(.ADDR_W(5), .DEPTH(4), .RESET_PC(5'h1C)) u_dut2 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .inst_valid(inst_valid2), .inst_ready(ready2),
    .inst_out(inst_out2), .inst_pc(inst_pc2),
    .redirect_valid(redir2), .redirect_pc(rpc2),
    .fifo_count(fifo_count2)
  );

  function automatic logic [31:0] word_at(input logic [4:0] pc);
    logic [4:0] a0, a1, a2, a3;
    a0 = pc;
    a1 = pc + 5'd1;
    a2 = pc + 5'd2;
    a3 = pc + 5'd3;
    return {mem[a0], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (q1.size() < 8) begin
      q1.push_back(nxt1);
      nxt1 = nxt1 + 5'd4;
    end
    while (q2.size() < 8) begin
      q2.push_back(nxt2);
      nxt2 = nxt2 + 5'd4;
    end
  endtask

  task automatic seed1(input logic [4:0] pc);
    q1.delete();
    nxt1 = pc;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    inst_ready = rdy;
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_out", inst_out, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_addr2", 32'(imem_addr2), 32'h1C);
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    seed1(5'h00);
    q2.delete();
    nxt2 = 5'h1C;
    refill();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [4:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    seed1({pc[4:2], 2'b00});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_vs_count", 32'(inst_valid), 32'(fifo_count != 3'd0));
      if (fifo_count > 3'd4) chk("count_bound", 32'(fifo_count), 32'd4);
      if (inst_valid && inst_ready && !redirect_valid) begin
        logic [4:0] e;
        e = q1.pop_front();
        chk("pop_pc", 32'(inst_pc), 32'(e));
        chk("pop_word", inst_out, word_at(e));
      end
      if (inst_valid2 && ready2) begin
        logic [4:0] e2;
        e2 = q2.pop_front();
        chk("pop_pc_1c", 32'(inst_pc2), 32'(e2));
        chk("pop_word_1c", inst_out2, word_at(e2));
      end
      refill();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // basic latency and throughput
    do_reset(1'b1);
    mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
    repeat (3) tick();
    chk("lat_valid_e3", 32'(inst_valid), 32'd0);
    tick();
    chk("lat_valid_e4", 32'(inst_valid), 32'd1);
    chk("lat_word", inst_out, 32'h8C220004);
    chk("lat_pc", 32'(inst_pc), 32'd0);
    chk("lat_pc_1c", 32'(inst_pc2), 32'h1C);
    tick();
    chk("lat_valid_e5", 32'(inst_valid), 32'd0);
    repeat (3) tick();
    chk("thr_valid_e8", 32'(inst_valid), 32'd1);
    chk("thr_pc_e8", 32'(inst_pc), 32'd4);
    chk("wrap_pc_1c", 32'(inst_pc2), 32'd0);
    repeat (12) tick();

    // fill to full, then HOLD
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) begin
      repeat (4) tick();
      chk("fill_count", 32'(fifo_count), 32'(i));
    end
    repeat (4) tick();
    chk("hold_addr", 32'(imem_addr), 32'h13);
    chk("hold_count", 32'(fifo_count), 32'd4);
    repeat (2) tick();
    chk("hold_addr_frz", 32'(imem_addr), 32'h13);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("hold_swap_count", 32'(fifo_count), 32'd4);
    chk("hold_resume_addr", 32'(imem_addr), 32'h14);
    inst_ready = 1'b1;
    repeat (40) tick();

    // redirect mid-assembly with two entries queued
    do_reset(1'b0);
    repeat (10) tick();
    chk("redir_pre_count", 32'(fifo_count), 32'd2);
    redirect(5'h0E);
    tick();
    redirect_valid = 1'b0;
    chk("redir_count", 32'(fifo_count), 32'd0);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h0C);
    repeat (3) tick();
    chk("redir_valid_k3", 32'(inst_valid), 32'd0);
    tick();
    chk("redir_valid_k4", 32'(inst_valid), 32'd1);
    chk("redir_pc_k4", 32'(inst_pc), 32'h0C);
    inst_ready = 1'b1;
    repeat (20) tick();

    // redirect coinciding with a pop and a completing push
    do_reset(1'b0);
    repeat (7) tick();
    inst_ready = 1'b1;
    redirect(5'h08);
    tick();
    redirect_valid = 1'b0;
    chk("rpp_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rpp_valid_low", 32'(inst_valid), 32'd0);
    end
    tick();
    chk("rpp_valid", 32'(inst_valid), 32'd1);
    chk("rpp_pc", 32'(inst_pc), 32'h08);
    repeat (20) tick();

    // fetch stall at byte_cnt=1
    do_reset(1'b1);
    tick();
    fetch_en = 1'b0;
    repeat (3) tick();
    chk("stall_addr", 32'(imem_addr), 32'd1);
    fetch_en = 1'b1;
    repeat (2) tick();
    chk("stall_valid_e6", 32'(inst_valid), 32'd0);
    tick();
    chk("stall_valid_e7", 32'(inst_valid), 32'd1);
    chk("stall_pc", 32'(inst_pc), 32'd0);
    chk("stall_word", inst_out, word_at(5'd0));

    // reset while in HOLD
    do_reset(1'b0);
    repeat (21) tick();
    chk("mid_hold_addr", 32'(imem_addr), 32'h13);
    do_reset(1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom % 4) != 0;
      fetch_en = ($urandom % 5) != 0;
      if ($urandom % 40 == 0) redirect(5'($urandom));
      else redirect_valid = 1'b0;
      if ($urandom % 700 == 0) do_reset(1'b1);
      else tick();
    end
    redirect_valid = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction fetch stage placed directly upstream of the single-cycle processor core. It reads the byte-wide (8-bit per location) instruction memory one byte per cycle, assembles big-endian 32-bit instruction words, and buffers them with their fetch PC in a small FIFO. The core consumes words through a valid/ready handshake and redirects fetch (branch, jump, jrsal, baln, jmnor, bgtzal, brnv targets) through a flush port.

## Interface
- ADDR_W, 5: instruction memory byte-address width; all address arithmetic wraps modulo 2^ADDR_W.
- DEPTH, 4: FIFO entries, power of two, at least 2.
- RESET_PC, 0: first fetch byte address after reset; bits [1:0] must be 0.

- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_en  in  1  1 = byte fetch may advance; 0 = freeze assembly (FIFO pop still works).
- imem_addr  out  ADDR_W  byte address presented to instruction memory.
- imem_rdata  in  8  byte at imem_addr, combinational (same-cycle) read.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  core accepts head this cycle.
- inst_out  out  32  instruction word at FIFO head.
- inst_pc  out  ADDR_W  byte address of inst_out's first byte.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0).
- fifo_count  out  log2(DEPTH)+1  number of valid entries.

## Operation
- Registers: fetch_pc (word aligned), byte_cnt (0..3), word assembly register asm[23:0], state {FETCH, HOLD}, FIFO with rd/wr pointers and count.
- imem_addr = fetch_pc + byte_cnt (mod 2^ADDR_W).
- FETCH, fetch_en=1: byte_cnt 0/1/2 capture imem_rdata into asm bits [23:16]/[15:8]/[7:0] and increment byte_cnt. byte_cnt=3: word = {asm, imem_rdata}; if FIFO can push, write {word, fetch_pc}, fetch_pc += 4, byte_cnt <= 0; else store word in hold register, go HOLD.
- FIFO can push when count < DEPTH, or count == DEPTH and a pop occurs in the same cycle.
- HOLD: present hold word; push it as soon as FIFO can push, then fetch_pc += 4, byte_cnt <= 0, go FETCH. imem_addr stays at fetch_pc+3 while in HOLD.
- fetch_en=0: byte_cnt, asm, fetch_pc frozen; HOLD push still permitted.
- Pop: inst_valid && inst_ready advances rd pointer.
- redirect_valid (highest priority): FIFO cleared (count 0, pointers 0), any concurrent pop and push discarded, partial asm and hold word dropped, fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}, byte_cnt <= 0, state FETCH.
- inst_out/inst_pc are FIFO head contents; when inst_valid=0 they hold the last written storage value (0 after reset) and must not be used.

## Timing
- Reset values: inst_valid 0, inst_out 0, inst_pc 0, fifo_count 0, imem_addr RESET_PC, state FETCH, byte_cnt 0.
- Fetch latency: 4 cycles per word. With fetch_en=1 from reset release, first push on the 4th rising edge; inst_valid high after it.
- Sustained throughput: one word per 4 cycles.
- Redirect latency: redirect sampled at edge k; imem_addr = redirect target during cycle after k; first redirected word valid after edge k+4.
- fifo_count updates on the same edge as push/pop; simultaneous push and pop leaves count unchanged.
- Wrap-around: fetch_pc 2^ADDR_W-4 followed by 0; byte address arithmetic also wraps.
- Reset asserted mid-assembly or mid-HOLD: outputs return to reset values asynchronously; fetch restarts at RESET_PC.

## Test plan
- Reset, imem bytes 0..3 = 8C 22 00 04, ready=1: inst_valid rises after 4th edge with inst_out 8C220004, inst_pc 0; next word pc 4 four cycles later.
- inst_ready=0, DEPTH=4: fifo_count 1,2,3,4 after edges 4,8,12,16; 5th word enters HOLD, imem_addr frozen at 0x13; raising ready for one cycle pops pc 0 and pushes pc 0x10 on the same edge, count stays 4.
- Redirect to 0x0E during byte_cnt=2 with 2 entries queued: next cycle fifo_count 0, inst_valid 0, imem_addr 0x0C; word from 0x0C valid 4 edges later.
- Redirect in the same cycle as a valid pop and a pending push: FIFO empty afterwards, no stale word ever appears at inst_out.
- RESET_PC=0x1C: words from 0x1C then 0x00, inst_pc 1C then 00.
- fetch_en low for 3 cycles at byte_cnt=1, then high: assembled word identical to uninterrupted case, delayed by 3 cycles; reset pulse mid-HOLD clears inst_valid immediately.
